rom_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction ROM. It accepts a byte stream, typically from a UART receiver, with a valid/ready handshake. It assembles big-endian 16-bit instruction words and writes them to sequential ROM addresses starting at 0. While loading, it holds the CPU in reset, and releases it once the declared word count has been written.

---
 rtl/hack_pkg.sv | 18 +
 rtl/rom_loader.sv | 153 +++++++++++++++
 tb/tb_rom_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared types and sizing for the boot-time ROM loader.
package hack_pkg;

  localparam int ADDR_W = 15;
  localparam int WORD_W = 16;
  localparam int unsigned ROM_DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    CNT_HI  = 3'd0,
    CNT_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WRITE   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } loader_state_e;

endpackage

// File: rtl/rom_loader.sv
// Boot loader: receives a length-prefixed byte stream, packs big-endian
// 16-bit words and writes them to consecutive ROM addresses from 0, holding
// the CPU in reset until the declared word count has been written.
//
// Handshake: a byte moves on a rising clk edge when rx_valid && rx_ready.
// rx_ready is decoded from the state register alone, so the sender may hold
// rx_valid high or drop it for any number of cycles; nothing times out.
module rom_loader
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_data,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  loader_state_e     state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic [15:0]       n_word;
  logic [ADDR_W:0]   addr_p1;

  // Byte-accepting states; pure decode of the state register.
  assign rx_ready = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                    (state_q == DATA_HI) || (state_q == DATA_LO);
  assign xfer     = rx_valid && rx_ready;

  // Next-state, byte assembly, address counter and registered flag values.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    n_word  = {count_q[15:8], rx_data};
    // One bit wider than the address so a full-depth load (N = 2^ADDR_W)
    // terminates on the last address instead of wrapping.
    addr_p1 = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};

    case (state_q)
      CNT_HI: begin
        if (xfer) begin
          count_d[15:8] = rx_data;
          state_d       = CNT_LO;
        end
      end
      CNT_LO: begin
        if (xfer) begin
          count_d = n_word;
          if (n_word == 16'd0) begin
            state_d = DONE;
          end else if (32'(n_word) > ROM_DEPTH) begin
            state_d = ERROR;
          end else begin
            state_d = DATA_HI;
            addr_d  = '0;
          end
        end
      end
      DATA_HI: begin
        if (xfer) begin
          hi_d    = rx_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (xfer) begin
          data_d  = {hi_q, rx_data};
          we_d    = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (addr_p1 == count_q[ADDR_W:0]) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_p1[ADDR_W-1:0];
          state_d = DATA_HI;
        end
      end
      DONE: begin
        if (start) begin
          state_d = CNT_HI;
          addr_d  = '0;
          count_d = '0;
        end
      end
      ERROR: begin
        if (start) begin
          state_d = CNT_HI;
          addr_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = CNT_HI;
    endcase

    // Flags follow the state being entered so they line up with it.
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
    cpu_reset_d = (state_d != DONE);
  end

  // State and datapath registers; asynchronous reset abandons any partial load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CNT_HI;
      count_q     <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rom_we     = we_q;
  assign rom_addr   = addr_q;
  assign rom_data   = data_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: byte driver, ROM-write scoreboard, report.
module tb_rom_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];
  logic        prev_we = 1'b0;

  rom_loader dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [14:0] a, input logic [15:0] d);
    return {1'b0, a, d};
  endfunction

  // scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (!reset && rom_we) begin
      if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
      else check("wr", {1'b0, rom_addr, rom_data}, exp_q.pop_front());
      if (prev_we) check("we_width", 32'd2, 32'd1);
    end
    prev_we <= rom_we;
  end

  // driver tasks; all run in the phase 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) check("rdy_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int cycles);
    rx_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  logic [7:0] gap_bytes[6];

  initial begin
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    check("rst_we",    32'(rom_we),     32'd0);
    check("rst_addr",  32'(rom_addr),   32'd0);
    check("rst_data",  32'(rom_data),   32'd0);
    check("rst_cpu",   32'(cpu_reset),  32'd1);
    check("rst_done",  32'(load_done),  32'd0);
    check("rst_err",   32'(load_error), 32'd0);
    check("rst_rdy",   32'(rx_ready),   32'd1);

    // 1: always-valid three-word load
    exp_q.push_back(wr(15'd0, 16'h1234));
    exp_q.push_back(wr(15'd1, 16'hABCD));
    exp_q.push_back(wr(15'd2, 16'h0007));
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00); send_byte(8'h07);
    rx_valid = 1'b0;
    check("t1_we_last",   32'(rom_we),    32'd1);
    check("t1_done_early",32'(load_done), 32'd0);
    check("t1_cpu_early", 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
    check("t1_done",  32'(load_done), 32'd1);
    check("t1_cpu",   32'(cpu_reset), 32'd0);
    check("t1_addr",  32'(rom_addr),  32'd2);
    check("t1_rdy",   32'(rx_ready),  32'd0);
    check("t1_empty", 32'(exp_q.size()), 32'd0);

    // 2: zero-length program
    pulse_start();
    check("t2_cpu_restart", 32'(cpu_reset), 32'd1);
    check("t2_addr0",       32'(rom_addr),  32'd0);
    send_byte(8'h00);
    check("t2_cpu_mid", 32'(cpu_reset), 32'd1);
    send_byte(8'h00);
    rx_valid = 1'b0;
    check("t2_done", 32'(load_done), 32'd1);
    check("t2_cpu",  32'(cpu_reset), 32'd0);
    check("t2_we",   32'(rom_we),    32'd0);

    // 3: oversize count 0x8001 -> error; then boundary 0x8000 is accepted
    pulse_start();
    send_byte(8'h80); send_byte(8'h01);
    check("t3_err", 32'(load_error), 32'd1);
    check("t3_cpu", 32'(cpu_reset),  32'd1);
    check("t3_rdy", 32'(rx_ready),   32'd0);
    rx_data = 8'h55; rx_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("t3_err_hold", 32'(load_error), 32'd1);
    check("t3_rdy_hold", 32'(rx_ready),   32'd0);
    pulse_start();
    check("t3_err_clr", 32'(load_error), 32'd0);
    check("t3_rdy_back",32'(rx_ready),   32'd1);
    send_byte(8'h80); send_byte(8'h00);
    rx_valid = 1'b0;
    check("t3_max_err", 32'(load_error), 32'd0);
    check("t3_max_rdy", 32'(rx_ready),   32'd1);
    check("t3_max_done",32'(load_done),  32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // 4: two words with 5-cycle gaps between every byte
    exp_q.push_back(wr(15'd0, 16'hFFFF));
    exp_q.push_back(wr(15'd1, 16'h0001));
    send_byte(8'h00); idle(5);
    send_byte(8'h02); idle(5);
    gap_bytes[0] = 8'hFF; gap_bytes[1] = 8'hFF;
    gap_bytes[2] = 8'h00; gap_bytes[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      send_byte(gap_bytes[i]);
      idle(5);
      if (i < 3) check($sformatf("t4_rdy_gap%0d", i), 32'(rx_ready), 32'd1);
    end
    check("t4_done",  32'(load_done), 32'd1);
    check("t4_addr",  32'(rom_addr),  32'd1);
    check("t4_empty", 32'(exp_q.size()), 32'd0);

    // 5: asynchronous reset in the middle of word 1 of a 4-word load
    pulse_start();
    exp_q.push_back(wr(15'd0, 16'h1111));
    send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h11);
    send_byte(8'h33);
    rx_valid = 1'b0;
    check("t5_addr_mid", 32'(rom_addr), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_we",   32'(rom_we),     32'd0);
    check("t5_rst_addr", 32'(rom_addr),   32'd0);
    check("t5_rst_data", 32'(rom_data),   32'd0);
    check("t5_rst_cpu",  32'(cpu_reset),  32'd1);
    check("t5_rst_done", 32'(load_done),  32'd0);
    check("t5_rst_rdy",  32'(rx_ready),   32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(wr(15'd0, 16'h55AA));
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'hAA);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_done",  32'(load_done), 32'd1);
    check("t5_cpu",   32'(cpu_reset), 32'd0);
    check("t5_empty", 32'(exp_q.size()), 32'd0);

    // 6: reload from DONE; start in DATA_HI is ignored
    pulse_start();
    check("t6_cpu_reload", 32'(cpu_reset), 32'd1);
    check("t6_done_clr",   32'(load_done), 32'd0);
    exp_q.push_back(wr(15'd0, 16'h002A));
    send_byte(8'h00); send_byte(8'h01);
    rx_valid = 1'b0;
    pulse_start();
    check("t6_ign_rdy", 32'(rx_ready),  32'd1);
    check("t6_ign_cpu", 32'(cpu_reset), 32'd1);
    send_byte(8'h00); send_byte(8'h2A);
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_done",  32'(load_done), 32'd1);
    check("t6_cpu",   32'(cpu_reset), 32'd0);
    check("t6_empty", 32'(exp_q.size()), 32'd0);

    // report
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
